muldiv_iter: RTL



---
 rtl/muldiv_iter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit (shift-add / restoring divide, one bit per cycle).
// Optional macro MULDIV_EARLY_OUT_EN: ops with a trivial result bypass CALC and complete one cycle after accept.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned DW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             in_ready_d, out_valid_d;
    logic [WIDTH-1:0] result_d;

    logic             in_div, a_sgn, b_sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [DW-1:0]    mul_next, div_next, prod_fix;
    logic [WIDTH-1:0] quo, rem, fix_res;

    // Operand decode: signedness per funct3, magnitudes as plain unsigned WIDTH-bit values.
    always_comb begin
        in_div = op[2];
        a_sgn  = in_div ? ~op[0] : (op[1:0] != 2'd3);
        b_sgn  = in_div ? ~op[0] : ~op[1];
        a_neg  = a_sgn & a[WIDTH-1];
        b_neg  = b_sgn & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = (b == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic             early;
    logic [WIDTH-1:0] early_res;

    // Trivial results known at accept: zero product, or divide by zero.
    always_comb begin
        early     = in_div ? b_zero : ((a == '0) || b_zero);
        early_res = in_div ? (op[1] ? a : '1) : '0;
    end
`endif

    // One iteration step; acc holds {product} for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[DW-1:1]};
        div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_next  = {(div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Sign correction and result selection.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[DW-1:WIDTH];
        case (op_q)
            3'd0:             fix_res = prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[DW-1:WIDTH];
            3'd4, 3'd5:       fix_res = neg_q ? -quo : quo;
            default:          fix_res = rneg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_d = early ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Next values of datapath and registered outputs.
    always_comb begin
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        result_d    = result;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    opnd_d = in_div ? b_mag : a_mag;
                    acc_d  = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                    cnt_d  = CNT_W'(WIDTH);
                    neg_d  = (a_neg ^ b_neg) & ~(in_div & b_zero);
                    rneg_d = a_neg;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) result_d = early_res;
`endif
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
            end
            FIX:     result_d = fix_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            result    <= result_d;
        end
    end
endmodule
